wshb_ram_slave: RTL and testbench

Wishbone B4 slave holding an on-chip 32-bit word memory. It answers classic single cycles and linear incrementing bursts from the masters already in the design: the VGA reader, the pattern generator, and the intercon arbitration path. It is used as a framebuffer stand-in behind the intercon when SDRAM is not needed, and as a responder model for the masters' benches. All accesses complete with a registered `ack`; out-of-range addresses complete with `err`.

---
 rtl/wshb_ram_slave.sv | 164 ++++++++++++++++
 tb/tb_wshb_ram_slave.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 slave backed by a DEPTH x 32-bit word memory.
// Serves classic single cycles (one access per two cycles) and linear
// incrementing bursts (one beat per cycle) with a registered ack; words at
// or beyond DEPTH terminate with err.
module wshb_ram_slave #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam int unsigned AW = $clog2(DEPTH);
  // One extra bit so the predicted address can reach DEPTH itself.
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLASSIC_ACK,
    S_BURST
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pa_q, pa_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_q, dat_d;

  logic [31:0]   mem [DEPTH];

  logic [29:0]   wi_c;
  logic          req_c;
  logic          in_range_c;
  logic          burst_req_c;
  logic          pa_match_c;
  logic          pa_in_range_c;
  logic          access_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_idx_c;
  logic          unused_c;

  // Address decode and request qualification.
  always_comb begin
    wi_c          = adr[31:2];
    req_c         = cyc & stb;
    in_range_c    = wi_c < 30'(DEPTH);
    burst_req_c   = (cti == 3'b010) && (bte == 2'b00);
    pa_match_c    = wi_c == 30'(pa_q);
    pa_in_range_c = pa_q < PW'(DEPTH);
    mem_idx_c     = wi_c[AW-1:0];
    unused_c      = ^adr[1:0];
  end

  // Next-state, response and memory-access decisions.
  always_comb begin
    state_d  = state_q;
    pa_d     = pa_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    access_c = 1'b0;
    mem_we_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (!in_range_c) begin
            err_d   = 1'b1;
            state_d = S_CLASSIC_ACK;
          end else begin
            access_c = 1'b1;
            ack_d    = 1'b1;
            if (burst_req_c) begin
              state_d = S_BURST;
              pa_d    = PW'({1'b0, wi_c[AW-1:0]}) + PW'(1);
            end else begin
              state_d = S_CLASSIC_ACK;
            end
          end
        end
      end
      S_CLASSIC_ACK: begin
        // Master is still presenting the acked request this cycle.
        state_d = S_IDLE;
      end
      S_BURST: begin
        if (!cyc) begin
          state_d = S_IDLE;
        end else if (stb) begin
          if (!pa_match_c) begin
            // Non-sequential address: insert a wait state and decode it fresh.
            state_d = S_IDLE;
          end else if (!pa_in_range_c) begin
            err_d   = 1'b1;
            state_d = S_CLASSIC_ACK;
          end else begin
            access_c = 1'b1;
            ack_d    = 1'b1;
            pa_d     = pa_q + PW'(1);
            if (cti == 3'b111) begin
              state_d = S_IDLE;
            end else if (burst_req_c) begin
              state_d = S_BURST;
            end else begin
              state_d = S_CLASSIC_ACK;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (access_c) begin
      if (we) begin
        mem_we_c = 1'b1;
      end else begin
        dat_d = mem[mem_idx_c];
      end
    end
  end

  // Control and response registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      pa_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      pa_q    <= pa_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Byte-lane memory write; contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          mem[mem_idx_c][8*i +: 8] <= dat_ms[8*i +: 8];
        end
      end
    end
  end

  assign dat_sm = dat_q;
  assign ack    = ack_q;
  assign err    = err_q;
  assign rty    = 1'b0;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Scoreboard bench for wshb_ram_slave: a master driver issues classic and
// burst transactions, a reference word memory predicts every response, and a
// monitor process pops and compares each ack/err as it appears.
module tb_wshb_ram_slave;

  localparam int unsigned DEPTH = 256;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          gap;
  } beat_t;

  typedef struct {
    logic        is_err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack, err, rty;

  logic [31:0] ref_mem [DEPTH];
  exp_t        sb_q [$];
  beat_t       beats [$];
  int          vectors;
  int          miscompares;

  wshb_ram_slave #(.DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cyc       (cyc),
    .stb       (stb),
    .we        (we),
    .adr       (adr),
    .sel       (sel),
    .dat_ms    (dat_ms),
    .cti       (cti),
    .bte       (bte),
    .dat_sm    (dat_sm),
    .ack       (ack),
    .err       (err),
    .rty       (rty)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int wi_of(input logic [31:0] a);
    return int'({2'b00, a[31:2]});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic wait_cycle();
    @(negedge sys_clk);
    #1;
  endtask

  // Reference model: each beat is either an err (word >= DEPTH), a write
  // merged into the reference memory lane by lane, or a full-word read.
  task automatic issue(input beat_t b);
    exp_t e;
    int   w;
    w     = wi_of(b.adr);
    e.dat = '0;
    e.chk = 1'b0;
    if (w >= int'(DEPTH)) begin
      e.is_err = 1'b1;
    end else begin
      e.is_err = 1'b0;
      if (b.we) begin
        for (int i = 0; i < 4; i++)
          if (b.sel[i]) ref_mem[w][8*i +: 8] = b.dat[8*i +: 8];
      end else begin
        e.chk = 1'b1;
        e.dat = ref_mem[w];
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n === 1'b1 && (ack === 1'b1 || err === 1'b1)) begin
        if (ack === 1'b1 && err === 1'b1) begin
          vectors++; miscompares++;
          $display("FAIL ack_err_overlap: got ack=1 err=1, expected only one");
        end
        if (cyc !== 1'b1) begin
          vectors++; miscompares++;
          $display("FAIL resp_without_cyc: got ack=%b err=%b with cyc=0, expected none", ack, err);
        end
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_resp: got ack=%b err=%b, expected no response", ack, err);
        end else begin
          e = sb_q.pop_front();
          check("resp_is_err", {31'b0, err}, {31'b0, e.is_err});
          if (e.chk && err !== 1'b1) check("read_data", dat_sm, e.dat);
        end
      end
    end
  endtask

  task automatic add_beat(input logic w_i, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input int g);
    beat_t b;
    b.we = w_i; b.adr = a; b.sel = s; b.dat = d; b.gap = g;
    beats.push_back(b);
  endtask

  task automatic run_classic(input logic w_i, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d);
    beat_t b;
    int    cnt;
    b.we = w_i; b.adr = a; b.sel = s; b.dat = d; b.gap = 0;
    cyc = 1'b1; stb = 1'b1; we = w_i; adr = a; sel = s; dat_ms = d;
    cti = 3'b000; bte = 2'b00;
    issue(b);
    cnt = 0;
    do begin
      wait_cycle();
      cnt++;
    end while (!(ack === 1'b1 || err === 1'b1) && cnt < 20);
    check("classic_latency", 32'(cnt), 32'd1);
    if (cnt >= 20) sb_q.delete();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wait_cycle();
  endtask

  // Issues the beats queue as one burst; a non-sequential beat is held an
  // extra cycle for the slave's wait state.
  task automatic run_burst();
    int    n, cnt, expc, extra, hold, prev_w;
    beat_t b;
    n = beats.size(); cnt = 0; expc = 0; prev_w = 0;
    cyc = 1'b1; bte = 2'b00;
    for (int k = 0; k < n; k++) begin
      b = beats[k];
      if (k > 0) begin
        for (int g = 0; g < b.gap; g++) begin
          stb = 1'b0;
          wait_cycle();
          cnt++; expc++;
        end
      end
      stb = 1'b1; we = b.we; adr = b.adr; sel = b.sel; dat_ms = b.dat;
      cti = (k == n - 1) ? 3'b111 : 3'b010;
      issue(b);
      hold = (k > 0 && wi_of(b.adr) != prev_w + 1) ? 2 : 1;
      prev_w = wi_of(b.adr);
      expc += hold;
      for (int h = 0; h < hold; h++) begin
        wait_cycle();
        cnt++;
      end
    end
    stb = 1'b0; cti = 3'b000; we = 1'b0;
    extra = 0;
    while (sb_q.size() != 0 && extra < 20) begin
      wait_cycle();
      extra++;
    end
    check("burst_cycles", 32'(cnt + extra), 32'(expc));
    sb_q.delete();
    cyc = 1'b0;
    wait_cycle();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    sys_rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_ms = '0;
    cti = 3'b000; bte = 2'b00;
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge sys_clk);
    #1;
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_dat_sm", dat_sm, 32'd0);
    check("rty_tied_low", {31'b0, rty}, 32'd0);
    sys_rst_n = 1'b1;
    wait_cycle();
    wait_cycle();

    // Preload the regions used below with burst writes.
    beats.delete();
    for (int i = 0; i < 80; i++) add_beat(1'b1, 32'(i) << 2, 4'hF, $urandom(), 0);
    run_burst();
    beats.delete();
    for (int i = 200; i < 208; i++) add_beat(1'b1, 32'(i) << 2, 4'hF, $urandom(), 0);
    run_burst();
    beats.delete();
    for (int i = int'(DEPTH) - 8; i < int'(DEPTH); i++)
      add_beat(1'b1, 32'(i) << 2, 4'hF, $urandom(), 0);
    run_burst();

    // Classic write then read.
    run_classic(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    run_classic(1'b0, 32'h10, 4'hF, 32'h0);
    check("classic_readback", dat_sm, 32'hDEADBEEF);

    // Byte-lane merge.
    run_classic(1'b1, 32'h20, 4'hF, 32'h11223344);
    run_classic(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    run_classic(1'b0, 32'h20, 4'hF, 32'h0);
    check("lanes_readback", dat_sm, 32'h11BB33DD);

    // Eight-beat burst read from address 0.
    beats.delete();
    for (int i = 0; i < 8; i++) add_beat(1'b0, 32'(i) << 2, 4'hF, 32'h0, 0);
    run_burst();

    // Burst with a two-cycle master gap at beat 3 and a jump at beat 5.
    beats.delete();
    for (int i = 0; i < 5; i++) add_beat(1'b0, 32'(10 + i) << 2, 4'hF, 32'h0, (i == 3) ? 2 : 0);
    for (int i = 0; i < 3; i++) add_beat(1'b0, 32'(40 + i) << 2, 4'hF, 32'h0, 0);
    run_burst();

    // Out-of-range classic read and a burst running off the end.
    run_classic(1'b0, 32'(DEPTH) << 2, 4'hF, 32'h0);
    beats.delete();
    for (int i = 0; i < 3; i++) add_beat(1'b0, 32'(int'(DEPTH) - 2 + i) << 2, 4'hF, 32'h0, 0);
    run_burst();

    // Reset in the middle of a write burst.
    run_classic(1'b1, 32'(50) << 2, 4'hF, 32'hCAFEF00D);
    run_classic(1'b0, 32'(50) << 2, 4'hF, 32'h0);
    cyc = 1'b1; bte = 2'b00;
    for (int k = 0; k < 4; k++) begin
      beat_t b;
      b.we = 1'b1; b.adr = 32'(200 + k) << 2; b.sel = 4'hF; b.dat = 32'hA5000000 + 32'(k); b.gap = 0;
      stb = 1'b1; we = 1'b1; adr = b.adr; sel = b.sel; dat_ms = b.dat; cti = 3'b010;
      issue(b);
      if (k < 3) wait_cycle();
    end
    @(posedge sys_clk);
    #2;
    check("pre_reset_ack", {31'b0, ack}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_reset_ack", {31'b0, ack}, 32'd0);
    check("mid_reset_err", {31'b0, err}, 32'd0);
    check("mid_reset_dat_sm", dat_sm, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    sb_q.delete();
    repeat (2) @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    wait_cycle();
    run_classic(1'b0, 32'(201) << 2, 4'hF, 32'h0);
    check("post_reset_word", dat_sm, 32'hA5000001);
    run_classic(1'b0, 32'(203) << 2, 4'hF, 32'h0);
    run_classic(1'b0, 32'(204) << 2, 4'hF, 32'h0);

    // Randomized mix of classic cycles and bursts.
    for (int t = 0; t < 80; t++) begin
      int   w, nw, len, gap;
      logic near, wr;
      if ($urandom_range(0, 1) == 0) begin
        w = ($urandom_range(0, 6) == 0) ? int'(DEPTH) - 4 + int'($urandom_range(0, 7))
                                        : int'($urandom_range(0, 79));
        run_classic(1'($urandom_range(0, 1)), (32'(w) << 2) | 32'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), $urandom());
      end else begin
        beats.delete();
        len  = int'($urandom_range(1, 8));
        near = ($urandom_range(0, 4) == 0);
        wr   = 1'($urandom_range(0, 1));
        w    = near ? int'(DEPTH) - 6 + int'($urandom_range(0, 7)) : int'($urandom_range(0, 71));
        for (int k = 0; k < len; k++) begin
          gap = 0;
          if (k > 0) begin
            w++;
            if (!near && $urandom_range(0, 7) == 0) begin
              nw = int'($urandom_range(0, 71));
              if (nw == w) nw = (nw + 3) % 72;
              w = nw;
            end
            if ($urandom_range(0, 7) == 0) gap = int'($urandom_range(1, 2));
          end
          add_beat(wr, (32'(w) << 2) | 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   $urandom(), gap);
          if (w >= int'(DEPTH)) break;
        end
        run_burst();
      end
    end

    repeat (3) wait_cycle();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
